// File: rtl/ql_run_sequencer_pkg.sv
// Shared types and constants for the Q-learning run sequencer and its watchdog.
package ql_pkg;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_RUN   = 2'd1,
        SEQ_DRAIN = 2'd2,
        SEQ_DONE  = 2'd3
    } seq_state_e;

    localparam logic [1:0] QL_ST_OK      = 2'd0;
    localparam logic [1:0] QL_ST_ABORTED = 2'd1;
    localparam logic [1:0] QL_ST_TIMEOUT = 2'd2;

    localparam logic QL_MODE_TRAIN  = 1'b0;
    localparam logic QL_MODE_RESUME = 1'b1;

    localparam int QL_CFG_W = 16;

endpackage

// File: rtl/ql_run_sequencer_wdt.sv
// Saturating run-cycle counter with an optional timeout compare.
// The compare exists only when QL_RUN_WDT_EN is defined.
module ql_run_wdt
    import ql_pkg::*;
#(
    parameter int CYC_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_count,
`ifdef QL_RUN_WDT_EN
    input  logic [CYC_W-1:0] i_timeout,
    output logic             o_expired,
`endif
    output logic [CYC_W-1:0] o_run_cycles
);

    localparam logic [CYC_W-1:0] ONE = {{(CYC_W-1){1'b0}}, 1'b1};

    logic [CYC_W-1:0] r_count;

    // Counter sticks at all-ones rather than wrapping back to a small value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_count && (r_count != '1)) begin
            r_count <= r_count + ONE;
        end
    end

    assign o_run_cycles = r_count;

`ifdef QL_RUN_WDT_EN
    assign o_expired = (i_timeout != '0) && (r_count >= i_timeout);
`endif

endmodule

// File: rtl/ql_run_sequencer.sv
// Host-side run sequencer: one accepted command becomes a start/active run of the control unit.
// Optional watchdog timeout is built only when QL_RUN_WDT_EN is defined.
module ql_run_sequencer
    import ql_pkg::*;
#(
    parameter int CYC_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_cmd_valid,
    output logic                o_cmd_ready,
    input  logic                i_cmd_mode,
    input  logic                i_cmd_abort,
    input  logic [QL_CFG_W-1:0] i_cfg_max_step,
    input  logic [QL_CFG_W-1:0] i_cfg_max_episode,
    input  logic [QL_CFG_W-1:0] i_cfg_seed,
    input  logic [CYC_W-1:0]    i_cfg_timeout,
    output logic                o_cu_start,
    output logic                o_cu_active,
    output logic [QL_CFG_W-1:0] o_cu_max_step,
    output logic [QL_CFG_W-1:0] o_cu_max_episode,
    output logic [QL_CFG_W-1:0] o_cu_seed,
    input  logic                i_cu_finish,
    input  logic                i_cu_idle,
    input  logic [QL_CFG_W-1:0] i_cu_ec,
    output logic                o_busy,
    output logic                o_done,
    output logic [1:0]          o_status,
    output logic [CYC_W-1:0]    o_run_cycles,
    output logic [QL_CFG_W-1:0] o_episodes
);

    seq_state_e r_state, w_next_state;

    logic                r_mode;
    logic [QL_CFG_W-1:0] r_max_step, r_max_episode, r_seed, r_episodes;
    logic [1:0]          r_status;
    logic                r_left_idle, r_abort_pend;

    logic w_accept, w_in_run, w_stop_abort, w_stop_wdt, w_exit_run;

    assign w_in_run     = (r_state == SEQ_RUN);
    assign w_accept     = (r_state == SEQ_IDLE) && i_cmd_valid && i_cu_idle;
    // Stops wait for left_idle so the control unit is never cut off before it has moved.
    assign w_stop_abort = (r_abort_pend || i_cmd_abort) && r_left_idle;
    assign w_exit_run   = w_in_run && (i_cu_finish || w_stop_abort || w_stop_wdt);

`ifdef QL_RUN_WDT_EN
    logic [CYC_W-1:0] r_timeout;
    logic             w_expired;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timeout <= '0;
        end else if (w_accept) begin
            r_timeout <= i_cfg_timeout;
        end
    end

    ql_run_wdt #(.CYC_W(CYC_W)) u_wdt (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (w_accept),
        .i_count      (w_in_run),
        .i_timeout    (r_timeout),
        .o_expired    (w_expired),
        .o_run_cycles (o_run_cycles)
    );

    assign w_stop_wdt = w_expired && r_left_idle;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^i_cfg_timeout;

    ql_run_wdt #(.CYC_W(CYC_W)) u_wdt (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (w_accept),
        .i_count      (w_in_run),
        .o_run_cycles (o_run_cycles)
    );

    assign w_stop_wdt = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SEQ_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            SEQ_IDLE:  if (w_accept) w_next_state = SEQ_RUN;
            SEQ_RUN:   if (w_exit_run) w_next_state = SEQ_DRAIN;
            SEQ_DRAIN: if (!i_cu_finish && i_cu_idle) w_next_state = SEQ_DONE;
            SEQ_DONE:  w_next_state = SEQ_IDLE;
            default:   w_next_state = SEQ_IDLE;
        endcase
    end

    // cmd_ready is gated by rst so every output reads 0 while reset is held.
    always_comb begin
        o_cmd_ready = (r_state == SEQ_IDLE) && i_cu_idle && !rst;
        o_cu_start  = w_in_run && (r_mode == QL_MODE_TRAIN);
        o_cu_active = w_in_run && (r_mode == QL_MODE_RESUME);
        o_busy      = (r_state == SEQ_RUN) || (r_state == SEQ_DRAIN);
        o_done      = (r_state == SEQ_DONE);
    end

    // Finish outranks abort, which outranks timeout, when they coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode        <= QL_MODE_TRAIN;
            r_max_step    <= '0;
            r_max_episode <= '0;
            r_seed        <= '0;
            r_episodes    <= '0;
            r_status      <= QL_ST_OK;
            r_left_idle   <= 1'b0;
            r_abort_pend  <= 1'b0;
        end else if (w_accept) begin
            r_mode        <= i_cmd_mode;
            r_max_step    <= i_cfg_max_step;
            r_max_episode <= i_cfg_max_episode;
            r_seed        <= i_cfg_seed;
            r_episodes    <= '0;
            r_status      <= QL_ST_OK;
            r_left_idle   <= 1'b0;
            r_abort_pend  <= 1'b0;
        end else if (w_in_run) begin
            if (!i_cu_idle) r_left_idle <= 1'b1;
            if (i_cmd_abort) r_abort_pend <= 1'b1;
            if (i_cu_finish) begin
                r_episodes <= i_cu_ec;
            end else if (w_stop_abort) begin
                r_status <= QL_ST_ABORTED;
            end else if (w_stop_wdt) begin
                r_status <= QL_ST_TIMEOUT;
            end
        end
    end

    assign o_cu_max_step    = r_max_step;
    assign o_cu_max_episode = r_max_episode;
    assign o_cu_seed        = r_seed;
    assign o_status         = r_status;
    assign o_episodes       = r_episodes;

endmodule

// File: tb/tb_ql_run_sequencer.sv
// Self-checking bench for ql_run_sequencer with a behavioural control-unit stand-in.
module tb_ql_run_sequencer;

    localparam int CYC_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cmdValid = 1'b0, cmdReady, cmdMode = 1'b0, cmdAbort = 1'b0;
    logic [15:0] cfgMaxStep = '0, cfgMaxEpisode = '0, cfgSeed = '0;
    logic [CYC_W-1:0] cfgTimeout = '0;
    logic cuStart, cuActive;
    logic [15:0] cuMaxStep, cuMaxEpisode, cuSeed;
    logic cuFinish = 1'b0, cuIdle = 1'b1;
    logic [15:0] cuEc = '0;
    logic busy, done;
    logic [1:0] status;
    logic [CYC_W-1:0] runCycles;
    logic [15:0] episodes;

    int testsRun = 0, testsFailed = 0;
    int leaveLat = 0, drainLat = 1;
    int refEc = 0;

    always #5 clk = ~clk;

    ql_run_sequencer #(.CYC_W(CYC_W)) dut (
        .clk(clk), .rst(rst),
        .i_cmd_valid(cmdValid), .o_cmd_ready(cmdReady), .i_cmd_mode(cmdMode), .i_cmd_abort(cmdAbort),
        .i_cfg_max_step(cfgMaxStep), .i_cfg_max_episode(cfgMaxEpisode), .i_cfg_seed(cfgSeed),
        .i_cfg_timeout(cfgTimeout),
        .o_cu_start(cuStart), .o_cu_active(cuActive),
        .o_cu_max_step(cuMaxStep), .o_cu_max_episode(cuMaxEpisode), .o_cu_seed(cuSeed),
        .i_cu_finish(cuFinish), .i_cu_idle(cuIdle), .i_cu_ec(cuEc),
        .o_busy(busy), .o_done(done), .o_status(status), .o_run_cycles(runCycles), .o_episodes(episodes)
    );

    // Control-unit stand-in: leaves idle after leaveLat, runs episodes of max_step cycles,
    // holds finish until its drive drops, then returns to idle after drainLat.
    int cuPhase = 0, cuCnt = 0, cuStep = 0, cuMaxStepR = 0, cuMaxEpR = 0;
    logic cuModeR = 1'b0;

    always @(posedge clk) begin
        case (cuPhase)
            0: if (cuStart || cuActive) begin
                cuModeR    <= cuActive;
                cuMaxStepR <= int'(cuMaxStep);
                cuMaxEpR   <= int'(cuMaxEpisode);
                cuStep     <= 0;
                if (!cuActive) cuEc <= '0;
                if (leaveLat == 0) begin cuIdle <= 1'b0; cuPhase <= 2; end
                else begin cuCnt <= leaveLat; cuPhase <= 1; end
            end
            1: begin
                if (!(cuStart || cuActive)) cuPhase <= 0;
                else if (cuCnt <= 1) begin cuIdle <= 1'b0; cuPhase <= 2; end
                else cuCnt <= cuCnt - 1;
            end
            2: begin
                if (!(cuStart || cuActive)) begin cuCnt <= drainLat; cuPhase <= 4; end
                else if (!cuModeR && cuMaxEpR == 0) begin cuFinish <= 1'b1; cuPhase <= 3; end
                else if (cuStep + 1 >= cuMaxStepR) begin
                    cuStep <= 0;
                    cuEc   <= cuEc + 16'd1;
                    if (cuModeR || int'(cuEc) + 1 >= cuMaxEpR) begin cuFinish <= 1'b1; cuPhase <= 3; end
                end else cuStep <= cuStep + 1;
            end
            3: if (!(cuStart || cuActive)) begin cuFinish <= 1'b0; cuCnt <= drainLat; cuPhase <= 4; end
            4: begin
                if (cuCnt <= 1) begin cuIdle <= 1'b1; cuPhase <= 0; end
                else cuCnt <= cuCnt - 1;
            end
            default: cuPhase <= 0;
        endcase
    end

    typedef struct {
        bit timedOut; bit wrongDrive; bit cfgBad; bit readyInRun; bit firstDrive;
        bit doneAfter; bit idleAtDone; bit busyAtDone;
        int driveCnt; int firstNotIdle; int firstLow; int finishCyc; int doneCyc;
        logic [1:0] st; logic [15:0] ep; logic [31:0] rc;
    } runObs_t;

    // Issues one command and records what the sequencer did, cycle indices relative to accept.
    task automatic runCmd(input bit mode, input logic [15:0] ms, input logic [15:0] me,
                          input logic [15:0] sd, input logic [31:0] to, input int abortAt,
                          input bit abortOnFin, input bit pokeValid, output runObs_t o);
        int waitCyc;
        o.timedOut = 0; o.wrongDrive = 0; o.cfgBad = 0; o.readyInRun = 0; o.firstDrive = 0;
        o.doneAfter = 0; o.idleAtDone = 0; o.busyAtDone = 0; o.driveCnt = 0;
        o.firstNotIdle = -1; o.firstLow = -1; o.finishCyc = -1; o.doneCyc = -1;
        o.st = '0; o.ep = '0; o.rc = '0;
        @(negedge clk);
        cmdMode = mode; cfgMaxStep = ms; cfgMaxEpisode = me; cfgSeed = sd; cfgTimeout = to;
        cmdValid = 1'b1;
        waitCyc = 0;
        while (cmdReady !== 1'b1 && waitCyc < 200) begin @(negedge clk); waitCyc++; end
        if (cmdReady !== 1'b1) begin cmdValid = 1'b0; o.timedOut = 1; return; end
        for (int c = 1; c < 3000; c++) begin
            @(negedge clk);
            cmdValid = 1'b0;
            cmdAbort = 1'b0;
            cmdMode = 1'($urandom); cfgMaxStep = 16'($urandom);
            cfgMaxEpisode = 16'($urandom); cfgSeed = 16'($urandom);
            if (c == abortAt) cmdAbort = 1'b1;
            if (pokeValid && (c == 2 || c == 3)) cmdValid = 1'b1;
            if (c == 1) o.firstDrive = (cuStart === 1'b1) || (cuActive === 1'b1);
            if (cuStart === 1'b1 || cuActive === 1'b1) begin
                o.driveCnt++;
                if ((mode && cuStart !== 1'b0) || (!mode && cuActive !== 1'b0)) o.wrongDrive = 1;
            end else if (o.firstLow < 0) o.firstLow = c;
            if (cuIdle === 1'b0 && o.firstNotIdle < 0) o.firstNotIdle = c;
            if (cuFinish === 1'b1 && o.finishCyc < 0) begin
                o.finishCyc = c;
                if (abortOnFin) cmdAbort = 1'b1;
            end
            if (busy === 1'b1 || done === 1'b1) begin
                if (cuMaxStep !== ms || cuMaxEpisode !== me || cuSeed !== sd) o.cfgBad = 1;
                if (cmdReady !== 1'b0) o.readyInRun = 1;
            end
            if (done === 1'b1) begin
                o.doneCyc = c; o.st = status; o.ep = episodes; o.rc = runCycles;
                o.idleAtDone = cuIdle; o.busyAtDone = busy;
                @(negedge clk);
                cmdAbort = 1'b0;
                o.doneAfter = done;
                return;
            end
        end
        cmdAbort = 1'b0;
        o.timedOut = 1;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #3;
        testsRun++;
        if ({cmdReady, busy, done, cuStart, cuActive, status} !== 7'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_ctrl: got %b expected 0", {cmdReady, busy, done, cuStart, cuActive, status});
        end
        testsRun++;
        if ({cuMaxStep, cuMaxEpisode, cuSeed, runCycles, episodes} !== 112'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_data: got %h expected 0", {cuMaxStep, cuMaxEpisode, cuSeed, runCycles, episodes});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        testsRun++;
        if (cmdReady !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL ready_after_reset: got %b expected 1", cmdReady);
        end
    endtask

    task automatic test_train_basic();
        runObs_t o;
        leaveLat = 1; drainLat = 1;
        runCmd(1'b0, 16'd4, 16'd3, 16'hACE1, 32'd0, -1, 1'b0, 1'b1, o);
        testsRun++;
        if (o.timedOut || !o.firstDrive || o.wrongDrive || o.cfgBad || o.readyInRun) begin
            testsFailed++;
            $display("[TB] FAIL train_flags: got to=%0d fd=%0d wd=%0d cfg=%0d rdy=%0d expected 0 1 0 0 0",
                     o.timedOut, o.firstDrive, o.wrongDrive, o.cfgBad, o.readyInRun);
        end
        testsRun++;
        if (o.firstLow !== o.finishCyc + 1) begin
            testsFailed++;
            $display("[TB] FAIL train_drop: got %0d expected %0d", o.firstLow, o.finishCyc + 1);
        end
        testsRun++;
        if (o.ep !== 16'd3 || o.st !== 2'd0) begin
            testsFailed++;
            $display("[TB] FAIL train_result: got ep=%0d st=%0d expected 3 0", o.ep, o.st);
        end
        testsRun++;
        if (o.doneCyc !== o.finishCyc + 4 || o.doneAfter !== 1'b0 || o.idleAtDone !== 1'b1 || o.busyAtDone !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL train_done: got cyc=%0d after=%0d idle=%0d busy=%0d expected %0d 0 1 0",
                     o.doneCyc, o.doneAfter, o.idleAtDone, o.busyAtDone, o.finishCyc + 4);
        end
        testsRun++;
        if (o.rc !== 32'(o.driveCnt)) begin
            testsFailed++;
            $display("[TB] FAIL train_cycles: got %0d expected %0d", o.rc, o.driveCnt);
        end
        refEc = 3;
    endtask

    task automatic test_resume();
        runObs_t o;
        leaveLat = 0; drainLat = 2;
        runCmd(1'b1, 16'd2, 16'd7, 16'h1234, 32'd0, -1, 1'b0, 1'b0, o);
        testsRun++;
        if (o.timedOut || !o.firstDrive || o.wrongDrive || o.cfgBad) begin
            testsFailed++;
            $display("[TB] FAIL resume_flags: got to=%0d fd=%0d wd=%0d cfg=%0d expected 0 1 0 0",
                     o.timedOut, o.firstDrive, o.wrongDrive, o.cfgBad);
        end
        testsRun++;
        if (o.st !== 2'd0 || o.ep !== 16'(refEc + 1) || o.firstLow !== o.finishCyc + 1) begin
            testsFailed++;
            $display("[TB] FAIL resume_result: got st=%0d ep=%0d drop=%0d expected 0 %0d %0d",
                     o.st, o.ep, o.firstLow, refEc + 1, o.finishCyc + 1);
        end
        refEc = refEc + 1;
    endtask

    task automatic test_zero_episode();
        runObs_t o;
        leaveLat = 0; drainLat = 1;
        runCmd(1'b0, 16'd5, 16'd0, 16'hBEEF, 32'd0, -1, 1'b0, 1'b0, o);
        testsRun++;
        if (o.timedOut || o.finishCyc < 1 || o.finishCyc > 4) begin
            testsFailed++;
            $display("[TB] FAIL zero_ep_finish: got cyc=%0d to=%0d expected 1..4", o.finishCyc, o.timedOut);
        end
        testsRun++;
        if (o.ep !== 16'd0 || o.st !== 2'd0 || o.rc !== 32'(o.driveCnt)) begin
            testsFailed++;
            $display("[TB] FAIL zero_ep_result: got ep=%0d st=%0d rc=%0d expected 0 0 %0d", o.ep, o.st, o.rc, o.driveCnt);
        end
        refEc = 0;
    endtask

    task automatic test_random();
        runObs_t o;
        bit m;
        logic [15:0] ms, me;
        int expEp;
        for (int i = 0; i < 6; i++) begin
            m  = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            ms = 16'($urandom_range(1, 5));
            me = 16'($urandom_range(0, 4));
            leaveLat = $urandom_range(0, 3);
            drainLat = $urandom_range(1, 3);
            runCmd(m, ms, me, 16'($urandom), 32'd0, -1, 1'b0, 1'b0, o);
            expEp = m ? refEc + 1 : int'(me);
            testsRun++;
            if (o.timedOut || o.st !== 2'd0 || o.ep !== 16'(expEp)) begin
                testsFailed++;
                $display("[TB] FAIL random_result[%0d]: got to=%0d st=%0d ep=%0d expected 0 0 %0d", i, o.timedOut, o.st, o.ep, expEp);
            end
            testsRun++;
            if (o.rc !== 32'(o.driveCnt) || o.firstLow !== o.finishCyc + 1 || o.wrongDrive || o.cfgBad) begin
                testsFailed++;
                $display("[TB] FAIL random_run[%0d]: got rc=%0d drop=%0d wd=%0d cfg=%0d expected %0d %0d 0 0",
                         i, o.rc, o.firstLow, o.wrongDrive, o.cfgBad, o.driveCnt, o.finishCyc + 1);
            end
            testsRun++;
            if (o.doneAfter !== 1'b0 || o.idleAtDone !== 1'b1) begin
                testsFailed++;
                $display("[TB] FAIL random_done[%0d]: got after=%0d idle=%0d expected 0 1", i, o.doneAfter, o.idleAtDone);
            end
            refEc = expEp;
        end
    endtask

    task automatic test_finish_abort_same();
        runObs_t o;
        leaveLat = 0; drainLat = 1;
        runCmd(1'b0, 16'd3, 16'd2, 16'h5A5A, 32'd0, -1, 1'b1, 1'b0, o);
        testsRun++;
        if (o.timedOut || o.st !== 2'd0 || o.ep !== 16'd2 || o.firstLow !== o.finishCyc + 1) begin
            testsFailed++;
            $display("[TB] FAIL finish_vs_abort: got to=%0d st=%0d ep=%0d drop=%0d expected 0 0 2 %0d",
                     o.timedOut, o.st, o.ep, o.firstLow, o.finishCyc + 1);
        end
    endtask

    task automatic test_abort();
        runObs_t o;
        leaveLat = 3; drainLat = 2;
        runCmd(1'b0, 16'd10, 16'd5, 16'h0F0F, 32'd0, 1, 1'b0, 1'b0, o);
        testsRun++;
        if (o.timedOut || o.firstNotIdle < 0 || o.firstLow <= o.firstNotIdle) begin
            testsFailed++;
            $display("[TB] FAIL abort_early_drop: got drop=%0d left_idle=%0d expected drop after left_idle", o.firstLow, o.firstNotIdle);
        end
        testsRun++;
        if (o.finishCyc >= 0 || o.st !== 2'd1 || o.ep !== 16'd0) begin
            testsFailed++;
            $display("[TB] FAIL abort_result: got fin=%0d st=%0d ep=%0d expected -1 1 0", o.finishCyc, o.st, o.ep);
        end
        testsRun++;
        if (o.rc !== 32'(o.driveCnt) || o.idleAtDone !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL abort_done: got rc=%0d idle=%0d expected %0d 1", o.rc, o.idleAtDone, o.driveCnt);
        end
    endtask

    task automatic test_timeout();
        runObs_t o;
        leaveLat = 0; drainLat = 1;
        runCmd(1'b0, 16'd50, 16'd4, 16'h7777, 32'd20, -1, 1'b0, 1'b0, o);
`ifdef QL_RUN_WDT_EN
        testsRun++;
        if (o.timedOut || o.st !== 2'd2 || o.ep !== 16'd0) begin
            testsFailed++;
            $display("[TB] FAIL timeout_result: got to=%0d st=%0d ep=%0d expected 0 2 0", o.timedOut, o.st, o.ep);
        end
        testsRun++;
        if (o.driveCnt != 21 || o.rc !== 32'd21) begin
            testsFailed++;
            $display("[TB] FAIL timeout_len: got drive=%0d rc=%0d expected 21 21", o.driveCnt, o.rc);
        end
`else
        testsRun++;
        if (o.timedOut || o.st !== 2'd0 || o.ep !== 16'd4) begin
            testsFailed++;
            $display("[TB] FAIL no_wdt_result: got to=%0d st=%0d ep=%0d expected 0 0 4", o.timedOut, o.st, o.ep);
        end
        testsRun++;
        if (o.rc !== 32'(o.driveCnt) || o.driveCnt <= 21) begin
            testsFailed++;
            $display("[TB] FAIL no_wdt_len: got rc=%0d drive=%0d expected rc=drive above 21", o.rc, o.driveCnt);
        end
`endif
    endtask

    task automatic test_reset_mid_run();
        int waitCyc;
        int badReady;
        leaveLat = 0; drainLat = 4;
        @(negedge clk);
        cmdMode = 1'b0; cfgMaxStep = 16'd50; cfgMaxEpisode = 16'd4; cfgSeed = 16'h4242; cfgTimeout = '0;
        cmdValid = 1'b1;
        waitCyc = 0;
        while (cmdReady !== 1'b1 && waitCyc < 200) begin @(negedge clk); waitCyc++; end
        @(negedge clk);
        cmdValid = 1'b0;
        repeat (6) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        testsRun++;
        if ({cmdReady, busy, done, cuStart, cuActive, status} !== 7'd0 ||
            {cuMaxStep, cuMaxEpisode, cuSeed, runCycles, episodes} !== 112'd0) begin
            testsFailed++;
            $display("[TB] FAIL async_reset: got ctrl=%b data=%h expected all 0",
                     {cmdReady, busy, done, cuStart, cuActive, status},
                     {cuMaxStep, cuMaxEpisode, cuSeed, runCycles, episodes});
        end
        @(negedge clk);
        rst = 1'b0;
        cmdMode = 1'b0; cfgMaxStep = 16'd2; cfgMaxEpisode = 16'd1; cfgSeed = 16'h0001;
        cmdValid = 1'b1;
        badReady = 0;
        waitCyc = 0;
        while (cuIdle !== 1'b1 && waitCyc < 100) begin
            if (cmdReady !== 1'b0 || busy !== 1'b0) badReady++;
            @(negedge clk);
            waitCyc++;
        end
        testsRun++;
        if (badReady != 0 || waitCyc == 0 || waitCyc >= 100) begin
            testsFailed++;
            $display("[TB] FAIL wait_idle: got early_accepts=%0d wait=%0d expected 0 and 1..99", badReady, waitCyc);
        end
        testsRun++;
        if (cmdReady !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL ready_on_idle: got %b expected 1", cmdReady);
        end
        @(negedge clk);
        cmdValid = 1'b0;
        testsRun++;
        if (busy !== 1'b1 || cuStart !== 1'b1 || cuMaxStep !== 16'd2) begin
            testsFailed++;
            $display("[TB] FAIL accept_after_reset: got busy=%b start=%b ms=%0d expected 1 1 2", busy, cuStart, cuMaxStep);
        end
        waitCyc = 0;
        while (done !== 1'b1 && waitCyc < 500) begin @(negedge clk); waitCyc++; end
        testsRun++;
        if (done !== 1'b1 || status !== 2'd0 || episodes !== 16'd1) begin
            testsFailed++;
            $display("[TB] FAIL run_after_reset: got done=%b st=%0d ep=%0d expected 1 0 1", done, status, episodes);
        end
    endtask

    initial begin
        test_reset();
        test_train_basic();
        test_resume();
        test_zero_episode();
        test_random();
        test_finish_abort_same();
        test_abort();
        test_timeout();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
